dut_mem: RTL and testbench

- Single-port synchronous memory slave: 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Accessed through a simple select/ready handshake: sel, wr_rd, addr, wdata in; rdata, ready out.
- Sits behind a bus master (testbench driver, or an upstream controller in the system) that holds a request until ready is seen.
- Optional programmable wait states model slower storage.

---
 rtl/mem_if.sv | 15 +
 rtl/dut_mem.sv | 102 ++++++++++
 tb/tb_dut_mem.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// Select/ready bus between a master and the dut_mem word store.
interface mem_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  sel;
   logic                  wr_rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;

   modport master (output sel, wr_rd, addr, wdata, input rdata, ready);
   modport slave  (input sel, wr_rd, addr, wdata, output rdata, ready);
endinterface

// File: rtl/dut_mem.sv
// Single-port word store behind a select/ready handshake, with optional
// wait states to model slower storage.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for sel; request fields captured on the accepting edge
// S_WAIT | burning WAIT_STATES cycles on the captured request
// S_RESP | access cycle; storage access and ready pulse land on its exit edge
//
// The access happens on the edge leaving S_RESP, so ready is high during
// the cycle the FSM spends back in S_IDLE. That gives the sel-to-ready
// latency of 1 + WAIT_STATES edges and one turnaround cycle per transfer.
module dut_mem #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_STATES = 0
) (
   input logic clk,
   input logic reset_n,
   mem_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            wait_cnt_q, wait_cnt_d;
   logic                  capture;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  ready_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Next-state and wait-counter logic; the counter runs down to a terminal count of 1.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      capture    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.sel) begin
               capture = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d    = S_WAIT;
                  wait_cnt_d = 4'(WAIT_STATES);
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt_q <= 4'd1) begin
               state_d    = S_RESP;
               wait_cnt_d = 4'd0;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter and captured request registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= 4'd0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (capture) begin
            wr_q    <= bus.wr_rd;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
         end
      end
   end

   // Storage access, read data and ready pulse; reset clears every word, so an aborted write never lands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= (state_q == S_RESP);
         if (state_q == S_RESP) begin
            if (wr_q) mem_q[addr_q] <= wdata_q;
            else      rdata_q       <= mem_q[addr_q];
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
endmodule

// File: tb/tb_dut_mem.sv
// Bench for dut_mem: one instance with no wait states, one with three.
module tb_dut_mem;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [15:0] mem0 [256];
   logic [15:0] mem1 [256];
   logic [15:0] last0;
   logic [15:0] last1;

   mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) b0 ();
   mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) b1 ();

   dut_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(0)) u0 (
      .clk(clk), .reset_n(reset_n), .bus(b0));
   dut_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(3)) u1 (
      .clk(clk), .reset_n(reset_n), .bus(b1));

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 16'h0;
         mem1[i] = 16'h0;
      end
      last0 = 16'h0;
      last1 = 16'h0;
   endtask

   task automatic drive(input bit d, input logic s, input logic w,
                        input logic [7:0] a, input logic [15:0] wd);
      if (d == 1'b0) begin
         b0.sel = s; b0.wr_rd = w; b0.addr = a; b0.wdata = wd;
      end else begin
         b1.sel = s; b1.wr_rd = w; b1.addr = a; b1.wdata = wd;
      end
   endtask

   // One transfer; lat counts edges after the accepting edge until ready, -1 on timeout.
   task automatic xfer(input bit d, input bit wr, input logic [7:0] a,
                       input logic [15:0] wd, input bit perturb,
                       output int lat, output logic [15:0] rd);
      logic rdy;
      @(negedge clk);
      drive(d, 1'b1, wr, a, wd);
      lat = -1;
      rd  = 16'hxxxx;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (i == 0 && perturb) drive(d, 1'b1, ~wr, a + 8'd1, ~wd);
         rdy = (d == 1'b0) ? b0.ready : b1.ready;
         if (rdy === 1'b1) begin
            lat = i;
            rd  = (d == 1'b0) ? b0.rdata : b1.rdata;
            break;
         end
      end
      drive(d, 1'b0, 1'bx, 8'hxx, 16'hxxxx);
   endtask

   task automatic test_reset();
      int lat;
      logic [15:0] rd;
      checks++;
      if (b0.ready !== 1'b0 || b1.ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: got %b/%b expected 0/0", b0.ready, b1.ready);
      end
      checks++;
      if (b0.rdata !== 16'h0 || b1.rdata !== 16'h0) begin
         failures++;
         $display("FAIL reset_rdata: got %h/%h expected 0000/0000", b0.rdata, b1.rdata);
      end
      xfer(1'b0, 1'b0, 8'h10, 16'h0, 1'b0, lat, rd);
      last0 = mem0[8'h10];
      checks++;
      if (lat !== 1 || rd !== 16'h0000) begin
         failures++;
         $display("FAIL reset_read10: got lat=%0d data=%h expected lat=1 data=0000", lat, rd);
      end
   endtask

   task automatic test_write_read();
      int lat;
      logic [15:0] rd;
      xfer(1'b0, 1'b1, 8'h05, 16'hBEEF, 1'b0, lat, rd);
      mem0[8'h05] = 16'hBEEF;
      checks++;
      if (lat !== 1) begin
         failures++;
         $display("FAIL write_latency: got %0d expected 1", lat);
      end
      @(posedge clk); #1;
      checks++;
      if (b0.ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_width: got %b expected 0 one cycle after pulse", b0.ready);
      end
      checks++;
      if (b0.rdata !== last0) begin
         failures++;
         $display("FAIL write_keeps_rdata: got %h expected %h", b0.rdata, last0);
      end
      xfer(1'b0, 1'b0, 8'h05, 16'h0, 1'b0, lat, rd);
      last0 = mem0[8'h05];
      checks++;
      if (lat !== 1 || rd !== 16'hBEEF) begin
         failures++;
         $display("FAIL read05: got lat=%0d data=%h expected lat=1 data=beef", lat, rd);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (b0.rdata !== 16'hBEEF) begin
         failures++;
         $display("FAIL rdata_hold: got %h expected beef", b0.rdata);
      end
   endtask

   task automatic test_boundaries();
      int lat;
      logic [15:0] rd;
      logic [7:0] ad [3];
      ad[0] = 8'h00; ad[1] = 8'hFF; ad[2] = 8'h01;
      xfer(1'b0, 1'b1, 8'h00, 16'h1234, 1'b0, lat, rd);
      mem0[8'h00] = 16'h1234;
      xfer(1'b0, 1'b1, 8'hFF, 16'hFFFF, 1'b0, lat, rd);
      mem0[8'hFF] = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         xfer(1'b0, 1'b0, ad[i], 16'h0, 1'b0, lat, rd);
         last0 = mem0[ad[i]];
         checks++;
         if (rd !== last0) begin
            failures++;
            $display("FAIL boundary_read[%h]: got %h expected %h", ad[i], rd, last0);
         end
      end
   endtask

   task automatic test_back_to_back();
      int k = 0;
      int last_cyc = -1;
      int lat;
      logic [15:0] rd;
      logic [7:0] a;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 8'h20, 16'h0060);
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge clk); #1;
         if (b0.ready === 1'b1) begin
            if (k < 8) mem0[8'h20 + k] = 16'((8'h20 + k) * 3);
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc != 2) begin
                  failures++;
                  $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 2", k, cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            k++;
            if (k < 8) begin
               a = 8'h20 + 8'(k);
               drive(1'b0, 1'b1, 1'b1, a, 16'(a * 3));
            end else begin
               drive(1'b0, 1'b0, 1'bx, 8'hxx, 16'hxxxx);
            end
         end
      end
      checks++;
      if (k != 8) begin
         failures++;
         $display("FAIL b2b_ready_count: got %0d expected 8", k);
      end
      for (int i = 0; i < 8; i++) begin
         a = 8'h20 + 8'(i);
         xfer(1'b0, 1'b0, a, 16'h0, 1'b0, lat, rd);
         last0 = mem0[a];
         checks++;
         if (rd !== 16'(a * 3)) begin
            failures++;
            $display("FAIL b2b_readback[%h]: got %h expected %h", a, rd, 16'(a * 3));
         end
      end
   endtask

   task automatic test_wait_states();
      int lat;
      logic [15:0] rd;
      xfer(1'b1, 1'b1, 8'h05, 16'h5A5A, 1'b0, lat, rd);
      mem1[8'h05] = 16'h5A5A;
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL ws_write_latency: got %0d expected 4", lat);
      end
      xfer(1'b1, 1'b0, 8'h05, 16'h0, 1'b1, lat, rd);
      last1 = mem1[8'h05];
      checks++;
      if (lat !== 4 || rd !== 16'h5A5A) begin
         failures++;
         $display("FAIL ws_read05: got lat=%0d data=%h expected lat=4 data=5a5a", lat, rd);
      end
      xfer(1'b1, 1'b0, 8'h06, 16'h0, 1'b0, lat, rd);
      last1 = mem1[8'h06];
      checks++;
      if (rd !== 16'h0000) begin
         failures++;
         $display("FAIL ws_ignored_inputs: addr 06 got %h expected 0000", rd);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen = 0;
      logic [15:0] rd;
      xfer(1'b1, 1'b1, 8'h31, 16'h1111, 1'b0, lat, rd);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 8'h30, 16'hAAAA);
      @(posedge clk);
      @(posedge clk); #1;
      reset_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (b1.ready !== 1'b0) seen++;
         if (i == 1) reset_n = 1'b1;
      end
      model_clear();
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL reset_abort_ready: got %0d ready cycles expected 0", seen);
      end
      checks++;
      if (b0.rdata !== 16'h0 || b1.rdata !== 16'h0) begin
         failures++;
         $display("FAIL reset_mid_rdata: got %h/%h expected 0000/0000", b0.rdata, b1.rdata);
      end
      xfer(1'b1, 1'b0, 8'h30, 16'h0, 1'b0, lat, rd);
      checks++;
      if (lat !== 4 || rd !== mem1[8'h30]) begin
         failures++;
         $display("FAIL reset_abort_write: got lat=%0d data=%h expected lat=4 data=%h", lat, rd, mem1[8'h30]);
      end
      xfer(1'b1, 1'b0, 8'h31, 16'h0, 1'b0, lat, rd);
      checks++;
      if (rd !== mem1[8'h31]) begin
         failures++;
         $display("FAIL reset_clears_mem: got %h expected %h", rd, mem1[8'h31]);
      end
      xfer(1'b0, 1'b0, 8'h05, 16'h0, 1'b0, lat, rd);
      checks++;
      if (rd !== mem0[8'h05]) begin
         failures++;
         $display("FAIL reset_clears_mem0: got %h expected %h", rd, mem0[8'h05]);
      end
      last0 = mem0[8'h05];
   endtask

   task automatic test_random();
      int lat;
      logic [15:0] rd;
      logic [15:0] wd;
      logic [7:0] a;
      bit wr;
      for (int n = 0; n < 60; n++) begin
         wr = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         wd = 16'($urandom);
         xfer(1'b0, wr, a, wd, 1'b0, lat, rd);
         checks++;
         if (lat !== 1) begin
            failures++;
            $display("FAIL rand_latency[%0d]: got %0d expected 1", n, lat);
         end
         if (wr) begin
            mem0[a] = wd;
            checks++;
            if (b0.rdata !== last0) begin
               failures++;
               $display("FAIL rand_write_rdata[%0d]: got %h expected %h", n, b0.rdata, last0);
            end
         end else begin
            last0 = mem0[a];
            checks++;
            if (rd !== last0) begin
               failures++;
               $display("FAIL rand_read[%0d] addr %h: got %h expected %h", n, a, rd, last0);
            end
         end
      end
   endtask

   initial begin
      model_clear();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      test_reset();
      test_write_read();
      test_boundaries();
      test_back_to_back();
      test_wait_states();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
